// File: rtl/ysyx_25030085_defs.sv
// Shared definitions for the NPC fetch/commit sequencer: FSM states,
// jump-kind codes, fault cause codes and the default reset PC.
package ysyx_25030085_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  // Kind of control transfer reported by execute at commit time.
  localparam logic [1:0] JUMP_SEQ  = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  // Sticky fault causes.
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUS      = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  // Instruction addresses must be word aligned (no compressed ISA).
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_25030085_npc_calc.sv
// Next-PC calculator: picks sequential, JAL or JALR target from the commit
// information and flags a target that is not word aligned.
module ysyx_25030085_npc_calc
  import ysyx_25030085_defs::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  jump_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_i,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  logic [31:0] target_s;

  // Select the next PC; JALR clears bit 0, all sums wrap modulo 2^32.
  always_comb begin
    target_s = pc_i + 32'd4;
    case (jump_i)
      JUMP_SEQ:  target_s = pc_i + 32'd4;
      JUMP_JAL:  target_s = pc_i + imm_i;
      JUMP_JALR: target_s = alu_i & 32'hFFFF_FFFE;
      default:   target_s = pc_i + 32'd4;
    endcase
  end

  assign target_o     = target_s;
  assign misaligned_o = is_misaligned(target_s);

endmodule

// File: rtl/ysyx_25030085_fetch_seq.sv
// Multi-cycle fetch/commit sequencer. Owns the architectural PC, fetches one
// instruction at a time over a valid/ready port, hands it to decode, waits for
// commit and then advances the PC. Misaligned targets, bus errors and fetch
// timeouts park the sequencer in a sticky fault state until reset.
module ysyx_25030085_fetch_seq
  import ysyx_25030085_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned TO_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        commit_valid,
  input  logic [1:0]  commit_jump,
  input  logic [31:0] commit_imm,
  input  logic [31:0] commit_alu,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [31:0] pc_out
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [TO_W-1:0]   cnt_q;
  logic              req_valid_q;
  logic              inst_valid_q;
  logic [31:0]       inst_q;
  logic [31:0]       inst_pc_q;
  logic              fault_q;
  logic [1:0]        fault_cause_q;
  logic [31:0]       fault_addr_q;

  logic [31:0]       npc_d;
  logic              npc_misaligned_s;

  ysyx_25030085_npc_calc u_npc_calc (
    .pc_i         (pc_q),
    .jump_i       (commit_jump),
    .imm_i        (commit_imm),
    .alu_i        (commit_alu),
    .target_o     (npc_d),
    .misaligned_o (npc_misaligned_s)
  );

  // Sequencer FSM with PC, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      cnt_q         <= '0;
      req_valid_q   <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_q        <= 32'h0000_0000;
      inst_pc_q     <= 32'h0000_0000;
      fault_q       <= 1'b0;
      fault_cause_q <= FAULT_NONE;
      fault_addr_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
        end
        S_REQ: begin
          // Coming out of boot the request flag is raised here; coming from
          // commit it is already up, so only the handshake remains.
          if (!req_valid_q) begin
            req_valid_q <= 1'b1;
          end else if (req_ready) begin
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            if (rsp_err) begin
              fault_q       <= 1'b1;
              fault_cause_q <= FAULT_BUS;
              fault_addr_q  <= pc_q;
              state_q       <= S_FAULT;
            end else begin
              inst_q       <= rsp_data;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end else if (cnt_q == CNT_LAST) begin
            fault_q       <= 1'b1;
            fault_cause_q <= FAULT_TIMEOUT;
            fault_addr_q  <= pc_q;
            state_q       <= S_FAULT;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (commit_valid) begin
            if (npc_misaligned_s) begin
              fault_q       <= 1'b1;
              fault_cause_q <= FAULT_MISALIGN;
              fault_addr_q  <= npc_d;
              state_q       <= S_FAULT;
            end else begin
              pc_q        <= npc_d;
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end
        default: begin
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          state_q      <= S_FAULT;
        end
      endcase
    end
  end

  assign req_valid   = req_valid_q;
  assign req_addr    = pc_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_ysyx_25030085_fetch_seq.sv
// Self-checking bench for the fetch/commit sequencer. The bench plays memory,
// decode and execute, and predicts PCs and faults from the architectural rules.
module tb_ysyx_25030085_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        rsp_err = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        commit_valid = 1'b0;
  logic [1:0]  commit_jump = 2'b00;
  logic [31:0] commit_imm = 32'h0;
  logic [31:0] commit_alu = 32'h0;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] pc_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  ysyx_25030085_fetch_seq #(.RESET_PC(32'h8000_0000), .TIMEOUT(4), .TO_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .commit_valid(commit_valid), .commit_jump(commit_jump),
    .commit_imm(commit_imm), .commit_alu(commit_alu),
    .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr),
    .pc_out(pc_out)
  );

  // Architectural next-PC rule.
  function automatic logic [31:0] exp_target(input logic [31:0] pc, input logic [1:0] j,
                                             input logic [31:0] imm, input logic [31:0] alu);
    if (j == 2'b01) return pc + imm;
    if (j == 2'b10) return alu & 32'hFFFF_FFFE;
    return pc + 32'd4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    m_pc = RST_PC;
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_req: req_valid=%b, required 1 within 20 cycles", req_valid);
    end
  endtask

  // Memory side: stall req_ready, accept, then answer after rsp_dly idle cycles.
  task automatic fetch(input int rdy_dly, input int rsp_dly, input logic [31:0] data,
                       input logic err, output logic [31:0] addr_seen);
    wait_req();
    addr_seen = req_addr;
    repeat (rdy_dly) step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    repeat (rsp_dly) step();
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    step();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = $urandom;
  endtask

  task automatic consume(input int dly);
    repeat (dly) step();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  task automatic commit(input int dly, input logic [1:0] j, input logic [31:0] imm,
                        input logic [31:0] alu);
    repeat (dly) step();
    commit_valid = 1'b1;
    commit_jump  = j;
    commit_imm   = imm;
    commit_alu   = alu;
    step();
    commit_valid = 1'b0;
    commit_imm   = $urandom;
    commit_alu   = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_cmp++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: req_valid=%b inst_valid=%b fault=%b, required 0/0/0",
               req_valid, inst_valid, fault);
    end
    n_cmp++;
    if (pc_out !== RST_PC || inst !== 32'h0 || fault_cause !== 2'b00 || fault_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_values: pc=%h inst=%h cause=%b faddr=%h, required %h/0/00/0",
               pc_out, inst, fault_cause, fault_addr, RST_PC);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL boot_edge1: req_valid=%b, required 0", req_valid);
    end
    step();
    n_cmp++;
    if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
      n_err++;
      $display("FAIL boot_edge2: req_valid=%b addr=%h, required 1/%h", req_valid, req_addr, RST_PC);
    end
    m_pc = RST_PC;
  endtask

  task automatic test_basic();
    logic [31:0] a;
    fetch(0, 0, 32'h0000_0013, 1'b0, a);
    n_cmp++;
    if (a !== 32'h8000_0000 || inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL basic_fetch: addr=%h iv=%b inst=%h ipc=%h, required 80000000/1/00000013/80000000",
               a, inst_valid, inst, inst_pc);
    end
    // A stray commit while decode still holds the instruction is ignored.
    commit(0, 2'b01, 32'h100, 32'h0);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst !== 32'h13 || pc_out !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL stray_commit: iv=%b inst=%h pc=%h, required 1/00000013/80000000",
               inst_valid, inst, pc_out);
    end
    consume(2);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_consume: inst_valid=%b, required 0", inst_valid);
    end
    commit(1, 2'b00, 32'h0, 32'h0);
    n_cmp++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004 || pc_out !== 32'h8000_0004) begin
      n_err++;
      $display("FAIL basic_seq: rv=%b addr=%h pc=%h, required 1/80000004/80000004",
               req_valid, req_addr, pc_out);
    end
    m_pc = 32'h8000_0004;
  endtask

  task automatic test_jumps();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      fetch(1, 1, 32'h0000_0013, 1'b0, a);
      consume(0);
      commit(0, 2'b11, 32'h0, 32'h0);
      m_pc = m_pc + 32'd4;
    end
    n_cmp++;
    if (pc_out !== 32'h8000_0010) begin
      n_err++;
      $display("FAIL seq_chain: pc=%h, required 80000010", pc_out);
    end
    fetch(0, 2, 32'h0000_006F, 1'b0, a);
    consume(1);
    commit(0, 2'b01, 32'hFFFF_FFF8, 32'h0);
    n_cmp++;
    if (pc_out !== 32'h8000_0008 || req_addr !== 32'h8000_0008 || req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL jal_back: pc=%h addr=%h rv=%b, required 80000008/80000008/1",
               pc_out, req_addr, req_valid);
    end
    fetch(0, 0, 32'h0000_0067, 1'b0, a);
    consume(0);
    commit(2, 2'b10, 32'h0, 32'h8000_0101);
    n_cmp++;
    if (pc_out !== 32'h8000_0100 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL jalr_ok: pc=%h fault=%b, required 80000100/0", pc_out, fault);
    end
    fetch(0, 0, 32'h0000_0067, 1'b0, a);
    consume(0);
    commit(0, 2'b10, 32'h0, 32'h8000_1003);
    n_cmp++;
    if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_addr !== 32'h8000_1002 ||
        pc_out !== 32'h8000_0100 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jalr_misalign: f=%b cause=%b faddr=%h pc=%h rv=%b, required 1/01/80001002/80000100/0",
               fault, fault_cause, fault_addr, pc_out, req_valid);
    end
    // Fault is terminal: responses and commits are ignored.
    rsp_valid = 1'b1;
    commit(1, 2'b00, 32'h0, 32'h0);
    rsp_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (fault !== 1'b1 || fault_cause !== 2'b01 || req_valid !== 1'b0 ||
        inst_valid !== 1'b0 || pc_out !== 32'h8000_0100) begin
      n_err++;
      $display("FAIL fault_sticky: f=%b cause=%b rv=%b iv=%b pc=%h, required 1/01/0/0/80000100",
               fault, fault_cause, req_valid, inst_valid, pc_out);
    end
  endtask

  task automatic test_bus_err();
    logic [31:0] a;
    do_reset();
    fetch(0, 0, 32'h13, 1'b0, a);
    consume(0);
    commit(0, 2'b00, 32'h0, 32'h0);
    fetch(2, 1, 32'h13, 1'b1, a);
    n_cmp++;
    if (fault !== 1'b1 || fault_cause !== 2'b10 || fault_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bus_err: f=%b cause=%b faddr=%h iv=%b, required 1/10/80000004/0",
               fault, fault_cause, fault_addr, inst_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    wait_req();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (fault !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: fault=%b after 3 cycles, required 0", fault);
    end
    step();
    n_cmp++;
    if (fault !== 1'b1 || fault_cause !== 2'b11 || fault_addr !== RST_PC) begin
      n_err++;
      $display("FAIL timeout: f=%b cause=%b faddr=%h after 4 cycles, required 1/11/%h",
               fault, fault_cause, fault_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, data, imm, alu, exp;
    logic [1:0]  j;
    int n_fault;
    n_fault = 0;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      data = $urandom;
      fetch($urandom_range(0, 3), $urandom_range(0, 3), data, 1'b0, a);
      n_cmp++;
      if (a !== m_pc || inst_valid !== 1'b1 || inst !== data || inst_pc !== m_pc) begin
        n_err++;
        $display("FAIL rand_fetch[%0d]: addr=%h iv=%b inst=%h ipc=%h, required %h/1/%h/%h",
                 it, a, inst_valid, inst, inst_pc, m_pc, data, m_pc);
      end
      consume($urandom_range(0, 3));
      j   = 2'($urandom_range(0, 3));
      imm = 32'(($urandom_range(0, 511) - 256) * 4) + (($urandom_range(0, 4) == 0) ? 32'd2 : 32'd0);
      alu = m_pc + 32'($urandom_range(0, 255) * 4) +
            (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      exp = exp_target(m_pc, j, imm, alu);
      commit($urandom_range(0, 3), j, imm, alu);
      if (exp % 4 != 0) begin
        n_fault++;
        n_cmp++;
        if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_addr !== exp || pc_out !== m_pc) begin
          n_err++;
          $display("FAIL rand_misalign[%0d]: f=%b cause=%b faddr=%h pc=%h, required 1/01/%h/%h",
                   it, fault, fault_cause, fault_addr, pc_out, exp, m_pc);
        end
        do_reset();
      end else begin
        n_cmp++;
        if (fault !== 1'b0 || pc_out !== exp || req_valid !== 1'b1 || req_addr !== exp) begin
          n_err++;
          $display("FAIL rand_commit[%0d]: f=%b pc=%h rv=%b addr=%h, required 0/%h/1/%h",
                   it, fault, pc_out, req_valid, req_addr, exp, exp);
        end
        m_pc = exp;
      end
    end
    $display("random: %0d misaligned commits exercised", n_fault);
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a;
    do_reset();
    fetch(0, 0, 32'h13, 1'b0, a);
    consume(0);
    commit(0, 2'b00, 32'h0, 32'h0);
    wait_req();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (pc_out !== RST_PC || req_valid !== 1'b0 || inst_valid !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: pc=%h rv=%b iv=%b f=%b, required %h/0/0/0",
               pc_out, req_valid, inst_valid, fault, RST_PC);
    end
    step();
    rst       = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    step();
    n_cmp++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL late_rsp_boot: iv=%b rv=%b, required 0/0", inst_valid, req_valid);
    end
    step();
    rsp_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== RST_PC) begin
      n_err++;
      $display("FAIL late_rsp_req: iv=%b rv=%b addr=%h, required 0/1/%h",
               inst_valid, req_valid, req_addr, RST_PC);
    end
    fetch(0, 0, 32'h0000_0093, 1'b0, a);
    n_cmp++;
    if (inst !== 32'h93 || inst_pc !== RST_PC || inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL recover_fetch: inst=%h ipc=%h iv=%b, required 00000093/%h/1",
               inst, inst_pc, inst_valid, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jumps();
    test_bus_err();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
